// File: rtl/ps2_scancode_ctrl.sv
// ps2_scancode_ctrl: pops scancode bytes from the PS/2 keyboard FIFO, folds E0/F0 prefixes
// into one key event per scancode, presents events on a valid/ready port, and tracks the
// held key, the press count, shift/ctrl state and a sticky FIFO overflow flag.
// Optional feature: define PS2CTRL_REPEAT_FILTER_EN to drop typematic repeat makes in DECODE.
module ps2_scancode_ctrl #(
    parameter int unsigned CNT_W    = 8,
    parameter logic [7:0]  EXT_CODE = 8'hE0,
    parameter logic [7:0]  BRK_CODE = 8'hF0
) (
    input  logic             clk_i,
    input  logic             clrn_i,
    input  logic [7:0]       ps2_data_i,
    input  logic             ps2_ready_i,
    input  logic             ps2_overflow_i,
    output logic             ps2_nextdata_n_o,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [7:0]       evt_code_o,
    output logic             evt_ext_o,
    output logic             evt_break_o,
    output logic             key_held_o,
    output logic [8:0]       held_code_o,
    output logic [CNT_W-1:0] press_cnt_o,
    output logic             shift_flag_o,
    output logic             ctrl_flag_o,
    output logic             err_ovf_o,
    input  logic             err_clr_i
);

    localparam logic [7:0] LShiftCode = 8'h12;
    localparam logic [7:0] RShiftCode = 8'h59;
    localparam logic [7:0] CtrlCode   = 8'h14;

    typedef enum logic [1:0] {StIdle, StPop, StDecode, StEmit} state_e;

    state_e           state_q;
    logic [7:0]       byte_q;
    logic             ext_pend_q;
    logic             brk_pend_q;
    logic             nextdata_n_q;
    logic             evt_valid_q;
    logic [7:0]       evt_code_q;
    logic             evt_ext_q;
    logic             evt_break_q;
    logic             key_held_q;
    logic [8:0]       held_code_q;
    logic [CNT_W-1:0] press_cnt_q;
    logic             shift_q;
    logic             ctrl_q;
    logic             err_ovf_q;

    logic [8:0] evt_key;
    logic [8:0] dec_key;
    logic       evt_is_shift;
    logic       evt_is_ctrl;
    logic       drop_repeat;

    assign evt_key      = {evt_ext_q, evt_code_q};
    assign dec_key      = {ext_pend_q, byte_q};
    assign evt_is_shift = !evt_ext_q && ((evt_code_q == LShiftCode) ||
                                         (evt_code_q == RShiftCode));
    assign evt_is_ctrl  = (evt_code_q == CtrlCode);

`ifdef PS2CTRL_REPEAT_FILTER_EN
    // A make of the key already held is a typematic repeat and is swallowed.
    assign drop_repeat = !brk_pend_q && key_held_q && (dec_key == held_code_q);
`else
    assign drop_repeat = 1'b0;
`endif

    // Byte sequencer FSM: pop, decode prefixes, emit one event and apply key-state updates.
    always_ff @(posedge clk_i or negedge clrn_i) begin
        if (!clrn_i) begin
            state_q      <= StIdle;
            byte_q       <= '0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            nextdata_n_q <= 1'b1;
            evt_valid_q  <= 1'b0;
            evt_code_q   <= '0;
            evt_ext_q    <= 1'b0;
            evt_break_q  <= 1'b0;
            key_held_q   <= 1'b0;
            held_code_q  <= '0;
            press_cnt_q  <= '0;
            shift_q      <= 1'b0;
            ctrl_q       <= 1'b0;
        end else begin
            // Pop strobe is low only for the single cycle spent in POP.
            nextdata_n_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (ps2_ready_i) begin
                        byte_q       <= ps2_data_i;
                        nextdata_n_q <= 1'b0;
                        state_q      <= StPop;
                    end
                end
                StPop: begin
                    state_q <= StDecode;
                end
                StDecode: begin
                    if (byte_q == EXT_CODE) begin
                        ext_pend_q <= 1'b1;
                        state_q    <= StIdle;
                    end else if (byte_q == BRK_CODE) begin
                        brk_pend_q <= 1'b1;
                        state_q    <= StIdle;
                    end else if (drop_repeat) begin
                        ext_pend_q <= 1'b0;
                        brk_pend_q <= 1'b0;
                        state_q    <= StIdle;
                    end else begin
                        evt_code_q  <= byte_q;
                        evt_ext_q   <= ext_pend_q;
                        evt_break_q <= brk_pend_q;
                        evt_valid_q <= 1'b1;
                        state_q     <= StEmit;
                    end
                end
                StEmit: begin
                    if (evt_ready_i) begin
                        evt_valid_q <= 1'b0;
                        ext_pend_q  <= 1'b0;
                        brk_pend_q  <= 1'b0;
                        state_q     <= StIdle;
                        if (evt_break_q) begin
                            if (evt_key == held_code_q) begin
                                key_held_q <= 1'b0;
                            end
                            if (evt_is_shift) begin
                                shift_q <= 1'b0;
                            end
                            if (evt_is_ctrl) begin
                                ctrl_q <= 1'b0;
                            end
                        end else begin
                            if (!key_held_q || (evt_key != held_code_q)) begin
                                press_cnt_q <= press_cnt_q + CNT_W'(1);
                            end
                            held_code_q <= evt_key;
                            key_held_q  <= 1'b1;
                            if (evt_is_shift) begin
                                shift_q <= 1'b1;
                            end
                            if (evt_is_ctrl) begin
                                ctrl_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Sticky overflow flag; a new overflow wins over a simultaneous clear.
    always_ff @(posedge clk_i or negedge clrn_i) begin
        if (!clrn_i) begin
            err_ovf_q <= 1'b0;
        end else if (ps2_overflow_i) begin
            err_ovf_q <= 1'b1;
        end else if (err_clr_i) begin
            err_ovf_q <= 1'b0;
        end
    end

    assign ps2_nextdata_n_o = nextdata_n_q;
    assign evt_valid_o      = evt_valid_q;
    assign evt_code_o       = evt_code_q;
    assign evt_ext_o        = evt_ext_q;
    assign evt_break_o      = evt_break_q;
    assign key_held_o       = key_held_q;
    assign held_code_o      = held_code_q;
    assign press_cnt_o      = press_cnt_q;
    assign shift_flag_o     = shift_q;
    assign ctrl_flag_o      = ctrl_q;
    assign err_ovf_o        = err_ovf_q;

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Bench for ps2_scancode_ctrl: a queue-based FIFO feeds bytes, a scancode-stream model
// predicts events and key state, and each scenario task checks the DUT against it.
module tb_ps2_scancode_ctrl;

`ifdef PS2CTRL_REPEAT_FILTER_EN
    localparam bit Filt = 1'b1;
`else
    localparam bit Filt = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clrn = 1'b1;
    logic [7:0] ps2_data = 8'h00;
    logic       ps2_ready = 1'b0;
    logic       ps2_overflow = 1'b0;
    logic       evt_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic       ps2_nextdata_n;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       key_held;
    logic [8:0] held_code;
    logic [7:0] press_cnt;
    logic       shift_flag;
    logic       ctrl_flag;
    logic       err_ovf;

    ps2_scancode_ctrl dut (
        .clk_i           (clk),
        .clrn_i          (clrn),
        .ps2_data_i      (ps2_data),
        .ps2_ready_i     (ps2_ready),
        .ps2_overflow_i  (ps2_overflow),
        .ps2_nextdata_n_o(ps2_nextdata_n),
        .evt_valid_o     (evt_valid),
        .evt_ready_i     (evt_ready),
        .evt_code_o      (evt_code),
        .evt_ext_o       (evt_ext),
        .evt_break_o     (evt_break),
        .key_held_o      (key_held),
        .held_code_o     (held_code),
        .press_cnt_o     (press_cnt),
        .shift_flag_o    (shift_flag),
        .ctrl_flag_o     (ctrl_flag),
        .err_ovf_o       (err_ovf),
        .err_clr_i       (err_clr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int pops = 0;

    logic [7:0] fifo[$];
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];

    // Reference model state, updated per byte of the scancode stream.
    bit       m_ext, m_brk, m_held, m_shift, m_ctrl;
    logic [8:0] m_code;
    int       m_cnt;

    logic [19:0] dstate;
    assign dstate = {key_held, held_code, press_cnt, shift_flag, ctrl_flag};

    function automatic logic [19:0] mstate();
        logic [7:0] c;
        c = m_cnt[7:0];
        return {m_held, m_code, c, m_shift, m_ctrl};
    endfunction

    function automatic void model_reset();
        m_ext = 0; m_brk = 0; m_held = 0; m_shift = 0; m_ctrl = 0;
        m_code = '0; m_cnt = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic [8:0] key;
        bit is_shift, is_ctrl;
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            key = {m_ext, b};
            is_shift = !m_ext && (b == 8'h12 || b == 8'h59);
            is_ctrl = (b == 8'h14);
            if (!(Filt && !m_brk && m_held && key == m_code)) begin
                exp_q.push_back({m_ext, m_brk, b});
                if (m_brk) begin
                    if (key == m_code) m_held = 0;
                    if (is_shift) m_shift = 0;
                    if (is_ctrl) m_ctrl = 0;
                end else begin
                    if (!m_held || key != m_code) m_cnt = (m_cnt + 1) % 256;
                    m_code = key;
                    m_held = 1;
                    if (is_shift) m_shift = 1;
                    if (is_ctrl) m_ctrl = 1;
                end
            end
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    // FIFO model: pops on a sampled low strobe, head visible shortly after the edge.
    always @(posedge clk) begin
        if (!ps2_nextdata_n) begin
            pops++;
            if (fifo.size() > 0) void'(fifo.pop_front());
            #1;
            ps2_ready = (fifo.size() > 0);
            if (fifo.size() > 0) ps2_data = fifo[0];
        end
    end

    // Consumer side: record every accepted event.
    always @(posedge clk) begin
        if (clrn && evt_valid && evt_ready) got_q.push_back({evt_ext, evt_break, evt_code});
    end

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        model_byte(b);
        ps2_data = fifo[0];
        ps2_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0;
        fifo.delete();
        ps2_ready = 1'b0;
        exp_q.delete();
        got_q.delete();
        model_reset();
        @(negedge clk);
        clrn = 1'b1;
        pops = 0;
    endtask

    task automatic drain(input int budget, output bit ok);
        int n = 0;
        evt_ready = 1'b1;
        while (!(fifo.size() == 0 && got_q.size() == exp_q.size() && !evt_valid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        ok = (n < budget);
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (ps2_nextdata_n !== 1'b1) begin
            miscompares++; $display("FAIL reset_nextdata got %b exp 1", ps2_nextdata_n);
        end
        vectors++;
        if ({evt_valid, evt_code, evt_ext, evt_break} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_evt got %b exp 0", {evt_valid, evt_code, evt_ext, evt_break});
        end
        vectors++;
        if ({dstate, err_ovf} !== 21'd0) begin
            miscompares++; $display("FAIL reset_state got %h exp 0", {dstate, err_ovf});
        end
        @(negedge clk);
        clrn = 1'b1;
        pops = 0;
    endtask

    task automatic test_make();
        int k = 0;
        bit ok;
        @(posedge clk);
        #1;
        push(8'h1C);
        evt_ready = 1'b1;
        while (!evt_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        vectors++;
        if (k !== 3) begin
            miscompares++; $display("FAIL make_latency got %0d edges exp 3", k);
        end
        drain(100, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL make_drain got timeout exp done"); end
        vectors++;
        if (pops !== 1) begin miscompares++; $display("FAIL make_pops got %0d exp 1", pops); end
        vectors++;
        if (dstate !== {1'b1, 9'h01C, 8'd1, 1'b0, 1'b0}) begin
            miscompares++; $display("FAIL make_state got %h exp %h", dstate, mstate());
        end
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL make_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL make_evt%0d got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_break();
        bit ok;
        pops = 0;
        push(8'hF0);
        push(8'h1C);
        drain(200, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL break_drain got timeout exp done"); end
        vectors++;
        if (pops !== 2) begin miscompares++; $display("FAIL break_pops got %0d exp 2", pops); end
        vectors++;
        if (dstate !== mstate()) begin
            miscompares++; $display("FAIL break_state got %h exp %h", dstate, mstate());
        end
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL break_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL break_evt%0d got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_ctrl();
        bit ok;
        pops = 0;
        push(8'hE0);
        push(8'h14);
        drain(200, ok);
        vectors++;
        if (!ok || ctrl_flag !== 1'b1) begin
            miscompares++; $display("FAIL ctrl_set got %b ok=%b exp 1", ctrl_flag, ok);
        end
        push(8'hE0);
        push(8'hF0);
        push(8'h14);
        drain(200, ok);
        vectors++;
        if (!ok || ctrl_flag !== 1'b0) begin
            miscompares++; $display("FAIL ctrl_clr got %b ok=%b exp 0", ctrl_flag, ok);
        end
        vectors++;
        if (pops !== 5) begin miscompares++; $display("FAIL ctrl_pops got %0d exp 5", pops); end
        vectors++;
        if (dstate !== mstate()) begin
            miscompares++; $display("FAIL ctrl_state got %h exp %h", dstate, mstate());
        end
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL ctrl_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL ctrl_evt%0d got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        int k = 0;
        int p0;
        bit ok;
        evt_ready = 1'b0;
        pops = 0;
        push(8'h1C);
        push(8'h32);
        while (!evt_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        vectors++;
        if (!evt_valid) begin miscompares++; $display("FAIL bp_valid got 0 exp 1"); end
        p0 = pops;
        repeat (10) begin
            @(posedge clk);
            #1;
            vectors++;
            if (!evt_valid || evt_code !== 8'h1C || pops !== p0 || fifo.size() !== 1) begin
                miscompares++;
                $display("FAIL bp_hold got v=%b code=%h pops=%0d fifo=%0d exp v=1 code=1c pops=%0d fifo=1",
                         evt_valid, evt_code, pops, fifo.size(), p0);
            end
        end
        drain(200, ok);
        vectors++;
        if (!ok || pops !== 2) begin
            miscompares++; $display("FAIL bp_pops got %0d ok=%b exp 2", pops, ok);
        end
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL bp_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL bp_evt%0d got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_repeat();
        bit ok;
        pops = 0;
        repeat (3) push(8'h1C);
        drain(200, ok);
        vectors++;
        if (!ok || pops !== 3) begin
            miscompares++; $display("FAIL rep_pops got %0d ok=%b exp 3", pops, ok);
        end
        vectors++;
        if (dstate !== mstate()) begin
            miscompares++; $display("FAIL rep_state got %h exp %h", dstate, mstate());
        end
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL rep_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL rep_evt%0d got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        for (int i = 0; i < 256; i++) push((i % 2 == 0) ? 8'h1C : 8'h22);
        drain(5000, ok);
        vectors++;
        if (!ok || press_cnt !== 8'd0) begin
            miscompares++; $display("FAIL wrap_cnt got %0d ok=%b exp 0", press_cnt, ok);
        end
        vectors++;
        if (dstate !== mstate()) begin
            miscompares++; $display("FAIL wrap_state got %h exp %h", dstate, mstate());
        end
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL wrap_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_overflow();
        @(negedge clk);
        ps2_overflow = 1'b1;
        err_clr = 1'b1;
        @(negedge clk);
        ps2_overflow = 1'b0;
        err_clr = 1'b0;
        vectors++;
        if (err_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_set got %b exp 1", err_ovf); end
        @(negedge clk);
        vectors++;
        if (err_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b exp 1", err_ovf); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        vectors++;
        if (err_ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clr got %b exp 0", err_ovf); end
    endtask

    task automatic test_reset_mid_emit();
        int k = 0;
        evt_ready = 1'b0;
        push(8'h1C);
        while (!evt_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        @(negedge clk);
        clrn = 1'b0;
        #1;
        vectors++;
        if ({evt_valid, evt_code, evt_ext, evt_break, dstate, err_ovf} !== 32'd0 ||
            ps2_nextdata_n !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_emit got %h nd=%b exp 0 nd=1",
                     {evt_valid, evt_code, evt_ext, evt_break, dstate, err_ovf}, ps2_nextdata_n);
        end
        model_reset();
        fifo.delete();
        ps2_ready = 1'b0;
        exp_q.delete();
        got_q.delete();
        @(negedge clk);
        clrn = 1'b1;
        pops = 0;
        repeat (6) @(negedge clk);
        vectors++;
        if (pops !== 0 || evt_valid !== 1'b0) begin
            miscompares++; $display("FAIL rst_after got pops=%0d v=%b exp 0 0", pops, evt_valid);
        end
    endtask

    task automatic test_random();
        logic [7:0] tbl[8];
        bit done = 0;
        bit ok;
        tbl = '{8'hE0, 8'hF0, 8'h1C, 8'h22, 8'h12, 8'h59, 8'h14, 8'h32};
        do_reset();
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    push(tbl[$urandom_range(0, 7)]);
                    repeat ($urandom_range(0, 6)) @(negedge clk);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    evt_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain(5000, ok);
        vectors++;
        if (!ok || pops !== 150) begin
            miscompares++; $display("FAIL rand_pops got %0d ok=%b exp 150", pops, ok);
        end
        vectors++;
        if (dstate !== mstate()) begin
            miscompares++; $display("FAIL rand_state got %h exp %h", dstate, mstate());
        end
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL rand_evt%0d got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        #2;
        test_reset();
        test_make();
        test_break();
        test_ctrl();
        test_backpressure();
        test_repeat();
        test_wrap();
        test_overflow();
        test_reset_mid_emit();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
